cook_countdown_timer: RTL and testbench

Cook-time entry and countdown core for the microwave. Accepts keypad digits and cooking-mode presets, runs the MM:SS countdown at one step per second while cooking, and handles start / stop / door interlock and the "+30 s" quick-add. Its BCD digit outputs drive the seven-segment stage, its `cooking` output gates the power stage, and its `done_pulse` output triggers the buzzer.

---
 rtl/cook_countdown_timer.sv | 188 ++++++++++++++++++
 tb/tb_cook_countdown_timer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_countdown_timer.sv
// Microwave cook-time entry and MM:SS countdown: keypad/preset entry, one BCD step per second
// while cooking, +30 s quick-add, pause/door interlock and a one-cycle completion pulse.
module cook_countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  set_time_digit,
  input  logic        digit_strobe,
  input  logic        preset_valid,
  input  logic [15:0] preset_time,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  output logic [3:0]  first_second_out,
  output logic [3:0]  second_second_out,
  output logic [3:0]  first_minute_out,
  output logic [3:0]  second_minute_out,
  output logic        cooking,
  output logic        paused,
  output logic        done_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          digit_hist_q, preset_hist_q, start_hist_q, stop_hist_q;
  logic          cooking_q, cooking_d;
  logic          paused_q, paused_d;
  logic          done_q, done_d;

  logic          digit_rise, preset_rise, start_rise, stop_rise;
  logic          digit_ok, preset_ok, tick_last;
  logic [15:0]   dec_time;

  // Time is held as {tens-min, units-min, tens-sec, units-sec}; seconds may exceed 59 when keyed in.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[15:8] != 8'd0) begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) begin
        r[11:8] = t[11:8] - 4'd1;
      end else begin
        r[11:8]  = 4'd9;
        r[15:12] = t[15:12] - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_add30(input logic [15:0] t);
    logic [15:0] r;
    logic [3:0]  st;
    r  = t;
    st = t[7:4] + 4'd3;
    if (st >= 4'd6) begin
      if (t[15:8] == 8'h99) begin
        r = 16'h9959;
      end else begin
        r[7:4] = st - 4'd6;
        if (t[11:8] >= 4'd9) begin
          r[11:8]  = 4'd0;
          r[15:12] = t[15:12] + 4'd1;
        end else begin
          r[11:8] = t[11:8] + 4'd1;
        end
      end
    end else begin
      r[7:4] = st;
    end
    return r;
  endfunction

  assign digit_rise  = digit_strobe & ~digit_hist_q;
  assign preset_rise = preset_valid & ~preset_hist_q;
  assign start_rise  = start & ~start_hist_q;
  assign stop_rise   = stop & ~stop_hist_q;
  assign digit_ok    = (set_time_digit <= 4'd9);
  assign preset_ok   = (preset_time[15:12] <= 4'd9) && (preset_time[11:8] <= 4'd9) &&
                       (preset_time[7:4] <= 4'd9) && (preset_time[3:0] <= 4'd9);
  assign tick_last   = (tick_q == TICK_LAST);
  assign dec_time    = bcd_dec(time_q);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_rise) begin
          time_d = 16'h0000;
        end else if (start_rise) begin
          if (!door_open && time_q != 16'h0000) begin
            state_d = S_COOK;
            tick_d  = '0;
          end
        end else if (preset_rise) begin
          if (preset_ok) time_d = preset_time;
        end else if (digit_rise && digit_ok) begin
          time_d = {time_q[11:0], set_time_digit};
        end
      end
      S_COOK: begin
        if (door_open || stop_rise) begin
          state_d = S_PAUSE;
        end else begin
          tick_d = tick_last ? '0 : tick_q + 1'b1;
          if (start_rise) begin
            time_d = bcd_add30(tick_last ? dec_time : time_q);
          end else if (tick_last) begin
            time_d = dec_time;
            if (dec_time == 16'h0000) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop_rise) begin
          state_d = S_IDLE;
          time_d  = 16'h0000;
        end else if (start_rise && !door_open) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        time_d = 16'h0000;
        if (door_open || stop_rise) begin
          state_d = S_IDLE;
        end else if (digit_rise && digit_ok) begin
          state_d = S_IDLE;
          time_d  = {12'h000, set_time_digit};
        end
      end
      default: state_d = S_IDLE;
    endcase
    cooking_d = (state_d == S_COOK);
    paused_d  = (state_d == S_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      time_q        <= 16'h0000;
      tick_q        <= '0;
      digit_hist_q  <= 1'b0;
      preset_hist_q <= 1'b0;
      start_hist_q  <= 1'b0;
      stop_hist_q   <= 1'b0;
      cooking_q     <= 1'b0;
      paused_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      time_q        <= time_d;
      tick_q        <= tick_d;
      digit_hist_q  <= digit_strobe;
      preset_hist_q <= preset_valid;
      start_hist_q  <= start;
      stop_hist_q   <= stop;
      cooking_q     <= cooking_d;
      paused_q      <= paused_d;
      done_q        <= done_d;
    end
  end

  assign first_second_out  = time_q[3:0];
  assign second_second_out = time_q[7:4];
  assign first_minute_out  = time_q[11:8];
  assign second_minute_out = time_q[15:12];
  assign cooking           = cooking_q;
  assign paused            = paused_q;
  assign done_pulse        = done_q;

endmodule

// File: tb/tb_cook_countdown_timer.sv
// Directed bench for cook_countdown_timer with TICKS_PER_SEC = 4; inputs change 1 time unit
// after a rising edge and outputs are sampled there too.
module tb_cook_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  set_time_digit = 4'd0;
  logic        digit_strobe = 1'b0;
  logic        preset_valid = 1'b0;
  logic [15:0] preset_time = 16'h0000;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        door_open = 1'b0;
  logic [3:0]  fs, ss, fm, sm;
  logic        cooking, paused, done_pulse;
  logic [15:0] disp;

  int total = 0;
  int bad = 0;

  assign disp = {sm, fm, ss, fs};

  always #5 clk = ~clk;

  cook_countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk(clk),
    .reset(reset),
    .set_time_digit(set_time_digit),
    .digit_strobe(digit_strobe),
    .preset_valid(preset_valid),
    .preset_time(preset_time),
    .start(start),
    .stop(stop),
    .door_open(door_open),
    .first_second_out(fs),
    .second_second_out(ss),
    .first_minute_out(fm),
    .second_minute_out(sm),
    .cooking(cooking),
    .paused(paused),
    .done_pulse(done_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    set_time_digit = d;
    digit_strobe = 1'b1;
    step();
    step();
    digit_strobe = 1'b0;
    step();
    $display("digit %h -> %h", d, disp);
  endtask

  task automatic load_preset(input logic [15:0] p);
    preset_time = p;
    preset_valid = 1'b1;
    step();
    preset_valid = 1'b0;
    step();
    $display("preset %h -> %h", p, disp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    $display("start -> %h cooking=%0b paused=%0b", disp, cooking, paused);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    $display("stop -> %h cooking=%0b paused=%0b", disp, cooking, paused);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++;
    if (disp !== 16'h0000) begin bad++; $display("FAIL reset_disp: got=%h exp=0000", disp); end
    total++;
    if ({cooking, paused, done_pulse} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got=%b exp=000", {cooking, paused, done_pulse});
    end
    $display("reset -> %h", disp);
  endtask

  task automatic test_entry_start();
    press_digit(4'd1);
    press_digit(4'd3);
    press_digit(4'd0);
    total++;
    if (disp !== 16'h0130) begin bad++; $display("FAIL entry_disp: got=%h exp=0130", disp); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (cooking !== 1'b1) begin bad++; $display("FAIL entry_cooking: got=%b exp=1", cooking); end
    repeat (3) step();
    total++;
    if (disp !== 16'h0130) begin bad++; $display("FAIL entry_before_tick: got=%h exp=0130", disp); end
    step();
    total++;
    if (disp !== 16'h0129) begin bad++; $display("FAIL entry_first_tick: got=%h exp=0129", disp); end
    repeat (120) step();
    total++;
    if (disp !== 16'h0059) begin bad++; $display("FAIL entry_31s: got=%h exp=0059", disp); end
    $display("countdown 31 s -> %h", disp);
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_quick_add();
    load_preset(16'h0145);
    pulse_start();
    start = 1'b1;
    step();
    total++;
    if (disp !== 16'h0215) begin bad++; $display("FAIL add30_carry: got=%h exp=0215", disp); end
    repeat (9) step();
    start = 1'b0;
    total++;
    if (disp !== 16'h0213) begin bad++; $display("FAIL add30_held_once: got=%h exp=0213", disp); end
    $display("held start -> %h", disp);
    pulse_stop();
    pulse_stop();
    load_preset(16'h9945);
    pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (disp !== 16'h9959) begin bad++; $display("FAIL add30_saturate: got=%h exp=9959", disp); end
    $display("quick-add at 99:45 -> %h", disp);
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_pause();
    load_preset(16'h0010);
    pulse_start();
    step();
    door_open = 1'b1;
    step();
    total++;
    if ({paused, cooking} !== 2'b10) begin bad++; $display("FAIL door_pause: got=%b exp=10", {paused, cooking}); end
    repeat (10) step();
    total++;
    if (disp !== 16'h0010) begin bad++; $display("FAIL pause_frozen: got=%h exp=0010", disp); end
    pulse_start();
    total++;
    if ({paused, cooking} !== 2'b10) begin bad++; $display("FAIL door_blocks_start: got=%b exp=10", {paused, cooking}); end
    door_open = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({paused, cooking} !== 2'b01) begin bad++; $display("FAIL resume: got=%b exp=01", {paused, cooking}); end
    step();
    total++;
    if (disp !== 16'h0010) begin bad++; $display("FAIL resume_hold: got=%h exp=0010", disp); end
    step();
    total++;
    if (disp !== 16'h0009) begin bad++; $display("FAIL resume_tick: got=%h exp=0009", disp); end
    pulse_stop();
    total++;
    if (paused !== 1'b1) begin bad++; $display("FAIL stop_pause: got=%b exp=1", paused); end
    pulse_stop();
    total++;
    if ({disp, paused, cooking} !== 18'h0) begin
      bad++; $display("FAIL stop_idle: got=%h/%b/%b exp=0000/0/0", disp, paused, cooking);
    end
  endtask

  task automatic test_completion();
    load_preset(16'h0003);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    total++;
    if ({disp, done_pulse} !== {16'h0001, 1'b0}) begin
      bad++; $display("FAIL done_early: got=%h/%b exp=0001/0", disp, done_pulse);
    end
    step();
    total++;
    if ({disp, done_pulse, cooking, paused} !== {16'h0000, 3'b100}) begin
      bad++; $display("FAIL done_reach: got=%h/%b%b%b exp=0000/100", disp, done_pulse, cooking, paused);
    end
    step();
    total++;
    if (done_pulse !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got=%b exp=0", done_pulse); end
    pulse_start();
    total++;
    if ({disp, cooking} !== {16'h0000, 1'b0}) begin
      bad++; $display("FAIL done_ignores_start: got=%h/%b exp=0000/0", disp, cooking);
    end
    press_digit(4'd5);
    total++;
    if ({disp, cooking} !== {16'h0005, 1'b0}) begin
      bad++; $display("FAIL done_digit: got=%h/%b exp=0005/0", disp, cooking);
    end
  endtask

  task automatic test_rejects();
    press_digit(4'hA);
    total++;
    if (disp !== 16'h0005) begin bad++; $display("FAIL reject_digit: got=%h exp=0005", disp); end
    load_preset(16'h12A0);
    total++;
    if (disp !== 16'h0005) begin bad++; $display("FAIL reject_preset: got=%h exp=0005", disp); end
    pulse_stop();
    total++;
    if (disp !== 16'h0000) begin bad++; $display("FAIL idle_stop_clear: got=%h exp=0000", disp); end
    pulse_start();
    total++;
    if (cooking !== 1'b0) begin bad++; $display("FAIL start_at_zero: got=%b exp=0", cooking); end
    press_digit(4'd7);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    total++;
    if ({disp, cooking} !== {16'h0000, 1'b0}) begin
      bad++; $display("FAIL start_stop_together: got=%h/%b exp=0000/0", disp, cooking);
    end
    step();
    for (int i = 1; i <= 5; i++) press_digit(4'(i));
    total++;
    if (disp !== 16'h2345) begin bad++; $display("FAIL digit_shift: got=%h exp=2345", disp); end
    pulse_stop();
  endtask

  task automatic test_reset_mid_cook();
    logic seen_done;
    load_preset(16'h0010);
    pulse_start();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({disp, cooking, paused, done_pulse} !== 19'h0) begin
      bad++; $display("FAIL reset_mid: got=%h/%b%b%b exp=0000/000", disp, cooking, paused, done_pulse);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done_pulse === 1'b1) seen_done = 1'b1;
    end
    total++;
    if ({seen_done, cooking, disp} !== 18'h0) begin
      bad++; $display("FAIL reset_mid_after: got=%b/%b/%h exp=0/0/0000", seen_done, cooking, disp);
    end
    $display("reset mid-cook -> %h", disp);
  endtask

  initial begin
    test_reset();
    test_entry_start();
    test_quick_add();
    test_pause();
    test_completion();
    test_rejects();
    test_reset_mid_cook();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
